// File: rtl/rv_pkg.sv
// Shared definitions for the multi-cycle RV32 control sequencer: opcode constants,
// FSM state encoding, PC/write-back mux selects and the decoded instruction class.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_TRAP      = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_JALR  = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_PC4  = 2'd2
  } wb_sel_e;

  // Exactly one flag is set for any opcode; unknown opcodes set illegal.
  typedef struct packed {
    logic alu_reg;
    logic alu_imm;
    logic branch;
    logic jal;
    logic jalr;
    logic auipc;
    logic lui;
    logic load;
    logic store;
    logic sys;
    logic illegal;
  } op_class_t;

endpackage

// File: rtl/opcode_classify.sv
// Combinational opcode decoder: maps IR[6:0] to one-hot instruction class flags.
module opcode_classify
  import rv_pkg::*;
(
  input  logic [6:0] opcode_i,
  output op_class_t  class_o
);

  // NOTE: every field gets a default before the case so no latch is inferred.
  always_comb begin
    class_o = '0;
    case (opcode_i)
      OPC_OP:     class_o.alu_reg = 1'b1;
      OPC_OP_IMM: class_o.alu_imm = 1'b1;
      OPC_BRANCH: class_o.branch  = 1'b1;
      OPC_JAL:    class_o.jal     = 1'b1;
      OPC_JALR:   class_o.jalr    = 1'b1;
      OPC_AUIPC:  class_o.auipc   = 1'b1;
      OPC_LUI:    class_o.lui     = 1'b1;
      OPC_LOAD:   class_o.load    = 1'b1;
      OPC_STORE:  class_o.store   = 1'b1;
      OPC_SYSTEM: class_o.sys     = 1'b1;
      default:    class_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle RV32 control FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP).
// Define SYSTEM_TRAP_EN to halt in TRAP on SYSTEM/illegal opcodes; otherwise they retire as NOPs.
module core_sequencer
  import rv_pkg::*;
#(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          inst,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 branch_taken,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [1:0]           pc_sel,
  output logic [1:0]           wb_sel,
  output logic                 alu_a_pc,
  output logic                 alu_b_imm,
  output logic [2:0]           state,
  output logic [INSTRET_W-1:0] instret,
  output logic                 halted
);

  state_e                 state_q, state_d;
  logic [6:0]             opcode_q;
  logic [INSTRET_W-1:0]   instret_q;
  op_class_t              cls;
  logic                   sys_or_illegal;
  pc_sel_e                pc_sel_d;
  wb_sel_e                wb_sel_d;
  logic                   unused_inst_bits;

  // Only the opcode field steers sequencing; the rest of the word belongs to the datapath.
  assign unused_inst_bits = ^inst[31:7];

  opcode_classify u_classify (
    .opcode_i (opcode_q),
    .class_o  (cls)
  );

  assign sys_or_illegal = cls.sys | cls.illegal;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: opcode_q has no reset; it is always written by a fetch before DECODE reads it.
  always_ff @(posedge clk) begin
    if (ir_we) begin
      opcode_q <= inst[6:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instret_q <= '0;
    end else if (pc_we) begin
      instret_q <= instret_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        if (cls.branch) begin
          state_d = ST_FETCH;
        end else if (cls.load || cls.store) begin
          state_d = ST_MEM;
        end else if (sys_or_illegal) begin
`ifdef SYSTEM_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        if (dmem_ready) state_d = cls.load ? ST_WRITEBACK : ST_FETCH;
      end
      ST_WRITEBACK: state_d = ST_FETCH;
      ST_TRAP: begin
`ifdef SYSTEM_TRAP_EN
        state_d = ST_TRAP;
`else
        state_d = ST_FETCH;
`endif
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    pc_we     = 1'b0;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    pc_sel_d  = PC_PLUS4;
    wb_sel_d  = WB_ALU;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_EXECUTE: begin
        alu_b_imm = cls.alu_imm | cls.load | cls.store | cls.jalr | cls.lui | cls.auipc;
        alu_a_pc  = cls.auipc | cls.jal;
        if (cls.branch) begin
          pc_we    = 1'b1;
          pc_sel_d = branch_taken ? PC_IMM : PC_PLUS4;
        end
`ifndef SYSTEM_TRAP_EN
        if (sys_or_illegal) pc_we = 1'b1;
`endif
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.store;
        // A store retires here; a load retires one cycle later in WRITEBACK.
        pc_we    = cls.store & dmem_ready;
      end
      ST_WRITEBACK: begin
        rf_we = 1'b1;
        pc_we = 1'b1;
        if (cls.load) begin
          wb_sel_d = WB_MEM;
        end else if (cls.jal || cls.jalr) begin
          wb_sel_d = WB_PC4;
        end
        if (cls.jal) begin
          pc_sel_d = PC_IMM;
        end else if (cls.jalr) begin
          pc_sel_d = PC_JALR;
        end
      end
      default: ;
    endcase
  end

  assign pc_sel  = pc_sel_d;
  assign wb_sel  = wb_sel_d;
  assign state   = state_q;
  assign instret = instret_q;

`ifdef SYSTEM_TRAP_EN
  assign halted = (state_q == ST_TRAP);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: a driver issues random instructions with random
// memory wait states and queues the expected retirement; a monitor checks each retirement.
module tb_core_sequencer;

  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   inst = '0;
  logic          imem_req, imem_ready = 1'b0;
  logic          dmem_req, dmem_we, dmem_ready = 1'b0;
  logic          branch_taken = 1'b0;
  logic          ir_we, rf_we, pc_we;
  logic [1:0]    pc_sel, wb_sel;
  logic          alu_a_pc, alu_b_imm;
  logic [2:0]    state;
  logic [IW-1:0] instret;
  logic          halted;

  core_sequencer #(.INSTRET_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst         (inst),
    .imem_req     (imem_req),
    .imem_ready   (imem_ready),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_ready   (dmem_ready),
    .branch_taken (branch_taken),
    .ir_we        (ir_we),
    .rf_we        (rf_we),
    .pc_we        (pc_we),
    .pc_sel       (pc_sel),
    .wb_sel       (wb_sel),
    .alu_a_pc     (alu_a_pc),
    .alu_b_imm    (alu_b_imm),
    .state        (state),
    .instret      (instret),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          lat;      // cycles from the ir_we cycle to the pc_we cycle
    int          dm_cnt;   // cycles with dmem_req high
    bit          dwe;
    int          rf_cnt;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    bit          a_pc;
    bit          b_imm;
    logic [IW-1:0] instret;
    bit          trap;
    bit          mem;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   retired = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what a whole instruction should do, given its opcode and environment.
  function automatic exp_t model(input logic [31:0] ins, input bit taken, input int dw);
    exp_t e;
    e = '{lat: 3, dm_cnt: 0, dwe: 0, rf_cnt: 1, pc_sel: 2'd0, wb_sel: 2'd0,
          a_pc: 0, b_imm: 0, instret: IW'(retired % (1 << IW)), trap: 0, mem: 0};
    case (ins[6:0])
      7'h33: ;
      7'h13: e.b_imm = 1;
      7'h37: e.b_imm = 1;
      7'h17: begin e.b_imm = 1; e.a_pc = 1; end
      7'h6f: begin e.a_pc = 1; e.wb_sel = 2; e.pc_sel = 1; end
      7'h67: begin e.b_imm = 1; e.wb_sel = 2; e.pc_sel = 2; end
      7'h63: begin e.lat = 2; e.rf_cnt = 0; e.pc_sel = taken ? 2'd1 : 2'd0; end
      7'h03: begin e.lat = 4 + dw; e.dm_cnt = dw + 1; e.b_imm = 1; e.wb_sel = 1; e.mem = 1; end
      7'h23: begin e.lat = 3 + dw; e.dm_cnt = dw + 1; e.dwe = 1; e.b_imm = 1; e.rf_cnt = 0; e.mem = 1; end
      default: begin
`ifdef SYSTEM_TRAP_EN
        e.trap = 1;
`endif
        e.lat = 2;
        e.rf_cnt = 0;
      end
    endcase
    return e;
  endfunction

  // Monitor: samples on the falling edge, compares every retirement against the queue.
  int   m_cyc = 0, m_start = 0, m_dm = 0, m_rf = 0;
  bit   m_active = 0, m_dwe = 0, m_apc = 0, m_bimm = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      m_active = 0;
    end else begin
      if (ir_we) begin
        m_active = 1; m_start = m_cyc; m_dm = 0; m_rf = 0;
        m_dwe = 0; m_apc = 0; m_bimm = 0;
      end else if (m_active) begin
        m_dm += int'(dmem_req);
        m_dwe |= dmem_we;
        m_rf += int'(rf_we);
        if (m_cyc == m_start + 2) begin
          m_apc = alu_a_pc;
          m_bimm = alu_b_imm;
        end
      end
      if (pc_we) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_retire: pc_we=1 with no instruction outstanding at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("latency", m_cyc - m_start, e.lat);
          check("pc_sel", pc_sel, e.pc_sel);
          check("wb_sel", wb_sel, e.wb_sel);
          check("rf_we_cycles", m_rf, e.rf_cnt);
          check("dmem_req_cycles", m_dm, e.dm_cnt);
          check("dmem_we", m_dwe, e.dwe);
          check("alu_a_pc", m_apc, e.a_pc);
          check("alu_b_imm", m_bimm, e.b_imm);
          check("instret", instret, e.instret);
        end
        m_active = 0;
      end
    end
    m_cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    step();
    check("rst_dmem_req", dmem_req, 0);
    check("rst_instret", instret, 0);
    check("rst_halted", halted, 0);
    check("rst_strobes", {ir_we, rf_we, pc_we, dmem_we}, 0);
    check("rst_fetching", imem_req, 1);
    exp_q.delete();
    retired = 0;
    reset = 1'b0;
  endtask

  task automatic wait_req(input bit dmem, output bit ok);
    int k;
    for (k = 0; k < 20 && !(dmem ? dmem_req : imem_req); k++) step();
    ok = dmem ? dmem_req : imem_req;
    check(dmem ? "dmem_req_timeout" : "imem_req_timeout", ok, 1);
  endtask

  task automatic fetch(input logic [31:0] ins, input int iw, input bit bt, output bit ok);
    wait_req(0, ok);
    if (!ok) return;
    for (int i = 0; i < iw; i++) begin
      imem_ready = 1'b0;
      dmem_ready = 1'($urandom_range(0, 1));  // must be ignored: no data request pending
      step();
    end
    dmem_ready = 1'b0;
    imem_ready = 1'b1;
    inst = ins;
    branch_taken = bt;
    step();
    imem_ready = 1'b0;
    inst = $urandom;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input bit bt);
    exp_t e;
    bit ok;
    e = model(ins, bt, dw);
    if (!e.trap) begin
      exp_q.push_back(e);
      retired++;
    end
    fetch(ins, iw, bt, ok);
    if (!ok) return;
    if (e.mem) begin
      wait_req(1, ok);
      if (!ok) return;
      for (int i = 0; i < dw; i++) begin
        imem_ready = 1'($urandom_range(0, 1));  // must be ignored: no fetch pending
        step();
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b1;
      step();
      dmem_ready = 1'b0;
    end
    if (e.trap) begin
      repeat (4) step();
      check("trap_halted", halted, 1);
      check("trap_instret_frozen", instret, IW'(retired % (1 << IW)));
      repeat (3) step();
      check("trap_holds", {halted, imem_req, pc_we}, 3'b100);
      do_reset();
    end
  endtask

  localparam logic [6:0] OPS [13] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
                                      7'h03, 7'h23, 7'h73, 7'h7f, 7'h00, 7'h0b};

  initial begin
    bit ok;
    step();
    do_reset();

    run_instr(32'h002081B3, 0, 0, 0);   // ADD
    run_instr(32'h0000A103, 0, 2, 0);   // LW, two data wait cycles
    run_instr(32'h0020A023, 1, 1, 0);   // SW
    run_instr(32'h00208463, 0, 0, 1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 0);   // BEQ not taken
    run_instr(32'h00000073, 0, 0, 0);   // ECALL

    // Abort a load mid-MEM: nothing retires and the counter clears.
    run_instr(32'h002081B3, 0, 0, 0);
    fetch(32'h0000A103, 0, 0, ok);
    wait_req(1, ok);
    step();
    reset = 1'b1;
    step();
    check("abort_dmem_req", dmem_req, 0);
    check("abort_instret", instret, 0);
    check("abort_pc_we", pc_we, 0);
    exp_q.delete();
    retired = 0;
    reset = 1'b0;

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ins;
      ins = {$urandom, 7'h00};
      ins[6:0] = OPS[$urandom_range(0, 12)];
      run_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    repeat (10) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter INSTRET_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 inst  in  32  instruction word from instruction memory; valid in a cycle where imem_ready=1.
REQ-005 imem_req  out  1  instruction fetch request.
REQ-006 imem_ready  in  1  fetch complete this cycle.
REQ-007 dmem_req, dmem_we  out  1 each  data access request; write enable for stores.
REQ-008 dmem_ready  in  1  data access complete this cycle.
REQ-009 branch_taken  in  1  branch comparison result from the ALU, valid in EXECUTE.
REQ-010 ir_we, rf_we, pc_we  out  1 each  instruction-register, register-file and PC write strobes.
REQ-011 pc_sel  out  2  0=PC+4, 1=PC+imm (B/J), 2=(rs1+Iimm)&~1.
REQ-012 wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4.
REQ-013 alu_a_pc, alu_b_imm  out  1 each  ALU operand A = PC; ALU operand B = immediate.
REQ-014 state  out  3  current FSM state (debug).
REQ-015 instret  out  INSTRET_W  retired-instruction count.
REQ-016 halted  out  1  sequencer stopped in TRAP.

Function
REQ-017 States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; unlisted encodings SHALL go to FETCH.
REQ-018 FETCH: imem_req=1 held until imem_ready=1; in that cycle ir_we=1 and next state DECODE.
REQ-019 DECODE: one cycle; opcode = IR[6:0] classified as ALUreg, ALUimm, Branch, JAL, JALR, AUIPC, LUI, Load, Store, SYSTEM, or illegal.
REQ-020 EXECUTE: one cycle; alu_b_imm=1 for ALUimm/Load/Store/JALR/LUI/AUIPC; alu_a_pc=1 for AUIPC/JAL.
REQ-021 Branch completes in EXECUTE: pc_we=1; pc_sel=1 if branch_taken else 0; next FETCH (3 cycles with zero-wait fetch).
REQ-022 Load/Store: EXECUTE -> MEM; dmem_req=1 held until dmem_ready=1; dmem_we=1 only for Store.
REQ-023 Store completes in MEM on dmem_ready: pc_we=1, pc_sel=0, next FETCH.
REQ-024 Load: MEM -> WRITEBACK on dmem_ready; WRITEBACK rf_we=1, wb_sel=1.
REQ-025 ALUreg/ALUimm/LUI/AUIPC: WRITEBACK rf_we=1, wb_sel=0, pc_we=1, pc_sel=0.
REQ-026 JAL/JALR: WRITEBACK rf_we=1, wb_sel=2, pc_we=1, pc_sel=1 (JAL) or 2 (JALR).
REQ-027 Every completion cycle (pc_we=1) SHALL increment instret by 1, wrapping modulo 2^INSTRET_W.
REQ-028 Outside the listed cycles all strobes and requests SHALL be 0; requests never drop before ready.
REQ-029 ready inputs asserted while their request is low SHALL be ignored.

Reset
REQ-030 reset=1 at a rising edge: state=FETCH, instret=0, halted=0, all strobes/requests 0 in the following cycle, regardless of prior state (including mid-MEM or TRAP); the aborted instruction is not retired.

Configuration
REQ-031 Macro SYSTEM_TRAP_EN defined: SYSTEM or illegal opcode in EXECUTE -> TRAP; TRAP holds halted=1, all strobes 0, no retirement, exit only by reset.
REQ-032 SYSTEM_TRAP_EN undefined: SYSTEM/illegal retire as NOP in EXECUTE (pc_we=1, pc_sel=0, rf_we=0); TRAP unreachable; halted tied 0.

Structure
REQ-033 Shared package rv_pkg holds opcode constants, state enum, pc_sel and wb_sel enums.
REQ-034 One sub-module, opcode_classify: combinational IR[6:0] -> one-hot class flags.

Verification
REQ-035 ADD 0x002081B3, imem_ready immediate -> ir_we cycle 1, rf_we/pc_we with wb_sel=0 in cycle 4, instret 0->1.
REQ-036 LW 0x0000A103, dmem_ready after 2 wait cycles -> dmem_req=1 for 3 cycles, dmem_we=0, then rf_we=1 with wb_sel=1.
REQ-037 SW 0x0020A023 -> dmem_req=1, dmem_we=1; pc_we in MEM on dmem_ready; rf_we never 1.
REQ-038 BEQ 0x00208463 with branch_taken=1 then 0 -> pc_we in EXECUTE with pc_sel=1 then 0; 3 cycles each.
REQ-039 ECALL 0x00000073 -> with SYSTEM_TRAP_EN halted=1 and instret frozen; without, retires as NOP.
REQ-040 reset asserted during MEM with dmem_ready=0 -> next cycle state=FETCH, dmem_req=0, instret=0.
